// File: rtl/core_fetch.sv
// Instruction fetch: PC, in-order word reads, small skid FIFO, registered INST/INST_PC/INST_VALID to decode.
// Latency: accept->INST_VALID 2 cycles, redirect->new INST_VALID 3 cycles; STALL holds output, credit limit throttles I_MEM_REQ.
module core_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          FIFO_DEPTH   = 2
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        I_MEM_REQ,
    output logic [31:0] I_MEM_ADDR,
    input  logic        I_MEM_READY,
    input  logic        I_MEM_VALID,
    input  logic [31:0] I_MEM_RDATA,
    input  logic        STALL,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic [31:0] INST,
    output logic [31:0] INST_PC,
    output logic        INST_VALID
);

    localparam int          PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [CNT_W:0] LIMIT = (CNT_W + 1)'(FIFO_DEPTH);

    logic [31:0]      r_fetch_pc;
    logic [31:0]      r_resp_pc;
    logic [CNT_W-1:0] r_outst;
    logic [CNT_W-1:0] r_discard;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [31:0]      r_fifo_inst [FIFO_DEPTH];
    logic [31:0]      r_fifo_pc   [FIFO_DEPTH];
    logic [31:0]      r_inst;
    logic [31:0]      r_inst_pc;
    logic             r_inst_vld;

    logic [31:0]      w_redir_pc;
    logic [CNT_W:0]   w_used;
    logic             w_req;
    logic             w_accept;
    logic             w_discard_hit;
    logic             w_keep;
    logic             w_empty;
    logic             w_pop;
    logic             w_bypass;
    logic             w_push;
    logic [CNT_W-1:0] w_outst_nxt;

    assign w_redir_pc    = REDIRECT_PC & 32'hFFFF_FFFC;
    assign w_used        = {1'b0, r_outst} + {1'b0, r_count};
    // Credits cover both in-flight reads and buffered words, so the FIFO can never overflow.
    assign w_req         = !RST && !REDIRECT && (w_used < LIMIT);
    assign w_accept      = w_req && I_MEM_READY;
    assign w_discard_hit = I_MEM_VALID && (r_discard != '0);
    assign w_keep        = I_MEM_VALID && !w_discard_hit && !REDIRECT;
    assign w_empty       = (r_count == '0);
    assign w_pop         = !REDIRECT && !STALL && !w_empty;
    assign w_bypass      = !REDIRECT && !STALL && w_empty && w_keep;
    assign w_push        = w_keep && !w_bypass;
    assign w_outst_nxt   = r_outst + CNT_W'(w_accept) - CNT_W'(I_MEM_VALID);

    assign I_MEM_REQ  = w_req;
    assign I_MEM_ADDR = r_fetch_pc;
    assign INST       = r_inst;
    assign INST_PC    = r_inst_pc;
    assign INST_VALID = r_inst_vld;

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_fifo_inst[r_wr_ptr] <= I_MEM_RDATA;
            r_fifo_pc[r_wr_ptr]   <= r_resp_pc;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_fetch_pc <= RESET_VECTOR & 32'hFFFF_FFFC;
            r_resp_pc  <= RESET_VECTOR & 32'hFFFF_FFFC;
            r_outst    <= '0;
            r_discard  <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_inst     <= NOP;
            r_inst_pc  <= '0;
            r_inst_vld <= 1'b0;
        end else if (REDIRECT) begin
            // Everything still in flight after this cycle belongs to the old path.
            r_fetch_pc <= w_redir_pc;
            r_resp_pc  <= w_redir_pc;
            r_outst    <= w_outst_nxt;
            r_discard  <= w_outst_nxt;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_inst     <= NOP;
            r_inst_vld <= 1'b0;
        end else begin
            if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            r_outst <= w_outst_nxt;
            if (w_discard_hit) begin
                r_discard <= r_discard - CNT_W'(1);
            end
            if (w_keep) begin
                r_resp_pc <= r_resp_pc + 32'd4;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (!STALL) begin
                if (!w_empty) begin
                    r_inst     <= r_fifo_inst[r_rd_ptr];
                    r_inst_pc  <= r_fifo_pc[r_rd_ptr];
                    r_inst_vld <= 1'b1;
                end else if (w_keep) begin
                    r_inst     <= I_MEM_RDATA;
                    r_inst_pc  <= r_resp_pc;
                    r_inst_vld <= 1'b1;
                end else begin
                    r_inst     <= NOP;
                    r_inst_vld <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_core_fetch.sv
// Bench for core_fetch: directed cycle table, randomized run against a queue-based model, async reset.
module tb_core_fetch;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RV    = 32'h0000_0100;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        CLK;
    logic        RST;
    logic        I_MEM_REQ;
    logic [31:0] I_MEM_ADDR;
    logic        I_MEM_READY;
    logic        I_MEM_VALID;
    logic [31:0] I_MEM_RDATA;
    logic        STALL;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic [31:0] INST;
    logic [31:0] INST_PC;
    logic        INST_VALID;

    core_fetch #(.RESET_VECTOR(RV), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST),
        .I_MEM_REQ(I_MEM_REQ), .I_MEM_ADDR(I_MEM_ADDR), .I_MEM_READY(I_MEM_READY),
        .I_MEM_VALID(I_MEM_VALID), .I_MEM_RDATA(I_MEM_RDATA),
        .STALL(STALL), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
        .INST(INST), .INST_PC(INST_PC), .INST_VALID(INST_VALID)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    function automatic logic [31:0] memw(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    typedef struct {
        bit          rdy;
        bit          vld;
        logic [31:0] raddr;
        bit          stall;
        bit          redir;
        logic [31:0] rpc;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_vld;
        logic [31:0] e_pc;
    } vec_t;
    vec_t tbl[$];

    task automatic add_row(input bit rdy, input bit vld, input logic [31:0] raddr,
                           input bit stall, input bit redir, input logic [31:0] rpc,
                           input bit e_req, input logic [31:0] e_addr,
                           input bit e_vld, input logic [31:0] e_pc);
        vec_t v;
        v.rdy = rdy; v.vld = vld; v.raddr = raddr; v.stall = stall; v.redir = redir;
        v.rpc = rpc; v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_pc = e_pc;
        tbl.push_back(v);
    endtask

    // Reference model: in-flight reads tagged stale on redirect, buffered PCs, output register.
    typedef struct { logic [31:0] pc; bit stale; } infl_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    infl_t       q_infl[$];
    logic [31:0] q_buf[$];
    mreq_t       mq[$];
    logic [31:0] m_fetch;
    logic [31:0] m_pc;
    bit          m_vld;
    int          cyc = 0;
    int          last_due = 0;

    task automatic model_reset();
        q_infl.delete();
        q_buf.delete();
        mq.delete();
        m_fetch  = RV;
        m_pc     = 32'h0;
        m_vld    = 1'b0;
        last_due = cyc;
    endtask

    task automatic drive_idle();
        I_MEM_READY = 1'b0; I_MEM_VALID = 1'b0; I_MEM_RDATA = 32'h0;
        STALL = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = 32'h0;
    endtask

    task automatic run_random(input int n);
        for (int k = 0; k < n; k++) begin
            bit          rdy, stl, rdr, vld, ereq, kept;
            logic [31:0] rpc;
            infl_t       e;
            @(negedge CLK);
            chk("rnd_inst_valid", 32'(INST_VALID), 32'(m_vld));
            chk("rnd_inst", INST, m_vld ? memw(m_pc) : NOP);
            if (m_vld) chk("rnd_inst_pc", INST_PC, m_pc);
            chk("rnd_pc_align", {30'b0, INST_PC[1:0]}, 32'h0);

            rdy = ($urandom_range(0, 3) != 0);
            stl = ($urandom_range(0, 3) == 0);
            rdr = ($urandom_range(0, 19) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : 32'($urandom);
            vld = (mq.size() > 0) && (mq[0].due <= cyc);
            I_MEM_READY = rdy; STALL = stl; REDIRECT = rdr; REDIRECT_PC = rpc;
            I_MEM_VALID = vld;
            I_MEM_RDATA = vld ? memw(mq[0].addr) : 32'h0;
            #1;
            ereq = !rdr && ((q_infl.size() + q_buf.size()) < DEPTH);
            chk("rnd_req", 32'(I_MEM_REQ), 32'(ereq));
            chk("rnd_addr", I_MEM_ADDR, m_fetch);

            kept = 1'b0;
            if (vld) begin
                if (q_infl.size() > 0) begin
                    e = q_infl.pop_front();
                    kept = !e.stale && !rdr;
                end
                void'(mq.pop_front());
            end
            if (I_MEM_REQ && rdy) begin
                mreq_t m;
                int    d;
                d = cyc + $urandom_range(1, 4);
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                m.addr = I_MEM_ADDR;
                m.due  = d;
                mq.push_back(m);
            end
            if (rdr) begin
                foreach (q_infl[i]) q_infl[i].stale = 1'b1;
                q_buf.delete();
                m_vld   = 1'b0;
                m_fetch = rpc & 32'hFFFF_FFFC;
            end else begin
                if (ereq && rdy) begin
                    infl_t f;
                    f.pc = m_fetch; f.stale = 1'b0;
                    q_infl.push_back(f);
                    m_fetch = m_fetch + 32'd4;
                end
                if (kept) q_buf.push_back(e.pc);
                if (!stl) begin
                    if (q_buf.size() > 0) begin
                        m_pc  = q_buf.pop_front();
                        m_vld = 1'b1;
                    end else begin
                        m_vld = 1'b0;
                    end
                end
            end
            cyc++;
        end
    endtask

    initial begin
        drive_idle();
        RST = 1'b1;
        #1;
        chk("rst_inst_valid", 32'(INST_VALID), 32'h0);
        chk("rst_inst", INST, NOP);
        chk("rst_inst_pc", INST_PC, 32'h0);
        chk("rst_req", 32'(I_MEM_REQ), 32'h0);

        //       rdy vld raddr     stl rdr rpc        req addr       vld pc
        add_row(1, 0, 32'h0,   0, 0, 32'h0,   1, 32'h100, 0, 32'h0);
        add_row(1, 1, 32'h100, 0, 0, 32'h0,   1, 32'h104, 1, 32'h100);
        add_row(1, 1, 32'h104, 0, 0, 32'h0,   1, 32'h108, 1, 32'h104);
        add_row(1, 1, 32'h108, 1, 0, 32'h0,   1, 32'h10C, 1, 32'h104);
        add_row(1, 1, 32'h10C, 1, 0, 32'h0,   0, 32'h110, 1, 32'h104);
        add_row(1, 0, 32'h0,   1, 0, 32'h0,   0, 32'h110, 1, 32'h104);
        add_row(1, 0, 32'h0,   0, 0, 32'h0,   0, 32'h110, 1, 32'h108);
        add_row(1, 0, 32'h0,   0, 0, 32'h0,   1, 32'h110, 1, 32'h10C);
        add_row(1, 1, 32'h110, 0, 0, 32'h0,   1, 32'h114, 1, 32'h110);
        add_row(0, 1, 32'h114, 0, 0, 32'h0,   1, 32'h118, 1, 32'h114);
        add_row(1, 0, 32'h0,   0, 0, 32'h0,   1, 32'h118, 0, 32'h0);
        add_row(0, 1, 32'h118, 0, 0, 32'h0,   1, 32'h11C, 1, 32'h118);
        add_row(1, 0, 32'h0,   0, 0, 32'h0,   1, 32'h11C, 0, 32'h0);
        add_row(1, 1, 32'h11C, 1, 1, 32'h503, 0, 32'h120, 0, 32'h0);
        add_row(1, 0, 32'h0,   0, 0, 32'h0,   1, 32'h500, 0, 32'h0);
        add_row(1, 1, 32'h500, 0, 0, 32'h0,   1, 32'h504, 1, 32'h500);
        add_row(0, 1, 32'h504, 0, 0, 32'h0,   1, 32'h508, 1, 32'h504);
        add_row(0, 0, 32'h0,   0, 0, 32'h0,   1, 32'h508, 0, 32'h0);
        add_row(1, 0, 32'h0,   0, 1, 32'h200, 0, 32'h508, 0, 32'h0);
        add_row(1, 0, 32'h0,   0, 0, 32'h0,   1, 32'h200, 0, 32'h0);
        add_row(1, 0, 32'h0,   0, 0, 32'h0,   1, 32'h204, 0, 32'h0);
        add_row(1, 0, 32'h0,   0, 0, 32'h0,   0, 32'h208, 0, 32'h0);
        add_row(1, 1, 32'h200, 0, 1, 32'h400, 0, 32'h208, 0, 32'h0);
        add_row(1, 1, 32'h204, 0, 0, 32'h0,   1, 32'h400, 0, 32'h0);
        add_row(0, 1, 32'h400, 0, 0, 32'h0,   1, 32'h404, 1, 32'h400);
        add_row(0, 0, 32'h0,   0, 0, 32'h0,   1, 32'h404, 0, 32'h0);

        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            I_MEM_READY = tbl[i].rdy;
            I_MEM_VALID = tbl[i].vld;
            I_MEM_RDATA = tbl[i].vld ? memw(tbl[i].raddr) : 32'h0;
            STALL       = tbl[i].stall;
            REDIRECT    = tbl[i].redir;
            REDIRECT_PC = tbl[i].rpc;
            #1;
            chk($sformatf("tbl%0d_req", i), 32'(I_MEM_REQ), 32'(tbl[i].e_req));
            chk($sformatf("tbl%0d_addr", i), I_MEM_ADDR, tbl[i].e_addr);
            @(negedge CLK);
            chk($sformatf("tbl%0d_vld", i), 32'(INST_VALID), 32'(tbl[i].e_vld));
            chk($sformatf("tbl%0d_inst", i), INST, tbl[i].e_vld ? memw(tbl[i].e_pc) : NOP);
            if (tbl[i].e_vld) chk($sformatf("tbl%0d_pc", i), INST_PC, tbl[i].e_pc);
        end

        drive_idle();
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        run_random(500);

        // Reset asserted between clock edges must act immediately.
        @(negedge CLK);
        drive_idle();
        #2 RST = 1'b1;
        #1;
        chk("arst_inst_valid", 32'(INST_VALID), 32'h0);
        chk("arst_inst", INST, NOP);
        chk("arst_inst_pc", INST_PC, 32'h0);
        chk("arst_req", 32'(I_MEM_REQ), 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        #1;
        chk("arst_restart_req", 32'(I_MEM_REQ), 32'h1);
        chk("arst_restart_addr", I_MEM_ADDR, RV);
        run_random(500);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
